// File: rtl/l1i_miss_fill_ctrl.sv
// rtl/l1i_miss_fill_ctrl.sv - L1I miss MSHR file with L2 request issue and lru-steered fill write
module l1i_miss_fill_ctrl #(
   parameter int NUM_SETS   = 64,
   parameter int SET_WIDTH  = $clog2(NUM_SETS),
   parameter int TAG_WIDTH  = 20,
   parameter int LINE_WIDTH = 512,
   parameter int NUM_MSHR   = 2,
   parameter int ID_WIDTH   = (NUM_MSHR > 1) ? $clog2(NUM_MSHR) : 1
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           miss_valid_i,
   output logic                           miss_ready_o,
   input  logic [SET_WIDTH-1:0]           miss_set_i,
   input  logic [TAG_WIDTH-1:0]           miss_tag_i,
   output logic                           l2_req_valid_o,
   input  logic                           l2_req_ready_i,
   output logic [TAG_WIDTH+SET_WIDTH-1:0] l2_req_addr_o,
   output logic [ID_WIDTH-1:0]            l2_req_id_o,
   input  logic                           l2_rsp_valid_i,
   output logic                           l2_rsp_ready_o,
   input  logic [ID_WIDTH-1:0]            l2_rsp_id_i,
   input  logic [LINE_WIDTH-1:0]          l2_rsp_data_i,
   output logic                           lru_fill_en_o,
   output logic [SET_WIDTH-1:0]           lru_fill_set_o,
   input  logic [3:0]                     lru_fill_way_oh_i,
   output logic                           fill_valid_o,
   output logic [SET_WIDTH-1:0]           fill_set_o,
   output logic [TAG_WIDTH-1:0]           fill_tag_o,
   output logic [3:0]                     fill_way_oh_o,
   output logic [LINE_WIDTH-1:0]          fill_data_o
);

   typedef enum logic [1:0] {E_IDLE, E_REQ_PEND, E_WAIT_RSP} ent_state_e;
   typedef enum logic {F_IDLE, F_WRITE} fill_state_e;

   ent_state_e                ent_state_q [NUM_MSHR];
   ent_state_e                ent_state_d [NUM_MSHR];
   logic [SET_WIDTH-1:0]      ent_set_q   [NUM_MSHR];
   logic [SET_WIDTH-1:0]      ent_set_d   [NUM_MSHR];
   logic [TAG_WIDTH-1:0]      ent_tag_q   [NUM_MSHR];
   logic [TAG_WIDTH-1:0]      ent_tag_d   [NUM_MSHR];

   logic                      req_hold_q;
   logic [ID_WIDTH-1:0]       req_hold_id_q;
   fill_state_e               f_state_q;
   logic [ID_WIDTH-1:0]       f_id_q;
   logic [LINE_WIDTH-1:0]     f_data_q;

   logic                      miss_match;
   logic                      any_idle;
   logic [ID_WIDTH-1:0]       alloc_idx;
   logic                      any_pend;
   logic [ID_WIDTH-1:0]       pend_idx;
   logic [ID_WIDTH-1:0]       req_id;
   logic                      alloc;
   logic                      req_fire;
   logic                      rsp_live;

   // Scan entries: merge detection, lowest idle slot and lowest pending request
   always_comb begin
      miss_match = 1'b0;
      any_idle   = 1'b0;
      alloc_idx  = '0;
      any_pend   = 1'b0;
      pend_idx   = '0;
      for (int i = NUM_MSHR - 1; i >= 0; i--) begin
         if (ent_state_q[i] == E_IDLE) begin
            any_idle  = 1'b1;
            alloc_idx = ID_WIDTH'(i);
         end else if (ent_set_q[i] == miss_set_i && ent_tag_q[i] == miss_tag_i) begin
            miss_match = 1'b1;
         end
         if (ent_state_q[i] == E_REQ_PEND) begin
            any_pend = 1'b1;
            pend_idx = ID_WIDTH'(i);
         end
      end
   end

   // A request left waiting keeps its grant so addr/id stay stable until accepted
   assign req_id         = req_hold_q ? req_hold_id_q : pend_idx;
   assign l2_req_valid_o = any_pend;
   assign l2_req_id_o    = req_id;
   assign l2_req_addr_o  = {ent_tag_q[req_id], ent_set_q[req_id]};
   assign req_fire       = any_pend && l2_req_ready_i;

   assign miss_ready_o   = any_idle || miss_match;
   assign alloc          = miss_valid_i && any_idle && !miss_match;

   // Responses are only taken between fills; ids not waiting for data are swallowed
   assign l2_rsp_ready_o = (f_state_q == F_IDLE);
   assign rsp_live       = l2_rsp_valid_i && l2_rsp_ready_o
                           && (int'(l2_rsp_id_i) < NUM_MSHR)
                           && (ent_state_q[l2_rsp_id_i] == E_WAIT_RSP);
   assign lru_fill_en_o  = rsp_live;
   assign lru_fill_set_o = rsp_live ? ent_set_q[l2_rsp_id_i] : '0;

   assign fill_valid_o   = (f_state_q == F_WRITE);
   assign fill_set_o     = fill_valid_o ? ent_set_q[f_id_q] : '0;
   assign fill_tag_o     = fill_valid_o ? ent_tag_q[f_id_q] : '0;
   assign fill_way_oh_o  = !fill_valid_o ? 4'b0000
                         : (lru_fill_way_oh_i == 4'b0000) ? 4'b0001 : lru_fill_way_oh_i;
   assign fill_data_o    = f_data_q;

   // Entry lifecycle: allocate, request accepted, freed at the end of its fill write
   always_comb begin
      for (int i = 0; i < NUM_MSHR; i++) begin
         ent_state_d[i] = ent_state_q[i];
         ent_set_d[i]   = ent_set_q[i];
         ent_tag_d[i]   = ent_tag_q[i];
         unique case (ent_state_q[i])
            E_IDLE: begin
               if (alloc && alloc_idx == ID_WIDTH'(i)) begin
                  ent_state_d[i] = E_REQ_PEND;
                  ent_set_d[i]   = miss_set_i;
                  ent_tag_d[i]   = miss_tag_i;
               end
            end
            E_REQ_PEND: begin
               if (req_fire && req_id == ID_WIDTH'(i)) ent_state_d[i] = E_WAIT_RSP;
            end
            E_WAIT_RSP: begin
               if (fill_valid_o && f_id_q == ID_WIDTH'(i)) ent_state_d[i] = E_IDLE;
            end
            default: ent_state_d[i] = E_IDLE;
         endcase
      end
   end

   // MSHR entry registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NUM_MSHR; i++) begin
            ent_state_q[i] <= E_IDLE;
            ent_set_q[i]   <= '0;
            ent_tag_q[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_MSHR; i++) begin
            ent_state_q[i] <= ent_state_d[i];
            ent_set_q[i]   <= ent_set_d[i];
            ent_tag_q[i]   <= ent_tag_d[i];
         end
      end
   end

   // Remember the granted entry while L2 is stalling the request
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         req_hold_q    <= 1'b0;
         req_hold_id_q <= '0;
      end else begin
         req_hold_q    <= any_pend && !l2_req_ready_i;
         req_hold_id_q <= req_id;
      end
   end

   // Fill FSM: capture a live response, write it the following cycle
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         f_state_q <= F_IDLE;
         f_id_q    <= '0;
         f_data_q  <= '0;
      end else begin
         unique case (f_state_q)
            F_IDLE: begin
               if (rsp_live) begin
                  f_id_q    <= l2_rsp_id_i;
                  f_data_q  <= l2_rsp_data_i;
                  f_state_q <= F_WRITE;
               end
            end
            F_WRITE: f_state_q <= F_IDLE;
            default: f_state_q <= F_IDLE;
         endcase
      end
   end

endmodule
